bus_trace_buffer: RTL

Parametrised debug capture block that sits beside the single-cycle CPU and records its `bus` output into a circular buffer. Capture starts on an arm pulse, continues through a masked-compare trigger for a programmable number of post-trigger samples, and then freezes. The buffer is drained oldest-first through a one-cycle-latency read port. Status is shown on a LED vector compatible with the board's eight LEDs.

---
 rtl/bus_trace_buffer_if.sv | 32 +++
 rtl/bus_trace_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bus_trace_buffer_if.sv
// Signal bundle between the traced system and the trace buffer.
// The slave modport is the trace buffer's view of the bundle.
interface bus_trace_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int LED_N = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] bus;
    logic             arm;
    logic [1:0]       mode;
    logic [WIDTH-1:0] trig_value;
    logic [WIDTH-1:0] trig_mask;
    logic             rd_req;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_last;
    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [LED_N-1:0] led;

    modport master (
        output bus, arm, mode, trig_value, trig_mask, rd_req,
        input  rd_data, rd_valid, rd_last, state, count, led
    );

    modport slave (
        input  bus, arm, mode, trig_value, trig_mask, rd_req,
        output rd_data, rd_valid, rd_last, state, count, led
    );
endinterface

// File: rtl/bus_trace_buffer.sv
// Circular capture of a traced bus: arm, masked-compare trigger, POST trailing
// samples, then freeze and drain oldest-first through a 1-cycle read port.
module bus_trace_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int POST  = 8,
    parameter int LED_N = 8
) (
    input logic               clk,
    input logic               reset,
    bus_trace_buffer_if.slave bif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [AW-1:0] POST_V   = AW'(POST);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_rd_cnt;
    logic [AW-1:0]    r_post_cnt;
    logic             r_wrapped;
    logic             r_first;
    logic [WIDTH-1:0] r_last_sample;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_rd_last;

    logic             w_match;
    logic             w_qual;
    logic             w_capture;
    logic             w_wrapped_nxt;
    logic             w_rd_end;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_start;
    logic [LED_N-1:0] w_led;

    always_comb begin
        w_match = ((bif.bus ^ bif.trig_value) & bif.trig_mask) == '0;
        w_qual  = 1'b1;
        case (bif.mode)
            2'b01:   w_qual = r_first || (bif.bus != r_last_sample);
            2'b10:   w_qual = w_match;
            default: w_qual = 1'b1;
        endcase
        w_capture     = !bif.arm && (r_state == S_ARMED || r_state == S_POST) && w_qual;
        w_wr_ptr_nxt  = r_wr_ptr + 1'b1;
        w_wrapped_nxt = r_wrapped || (r_wr_ptr == LAST_IDX);
        // Oldest entry as it will stand after the final write lands this edge.
        w_rd_start    = w_wrapped_nxt ? w_wr_ptr_nxt : '0;
        w_rd_end      = (r_rd_cnt + 1'b1) == r_count;
    end

    always_ff @(posedge clk) begin
        if (!reset && w_capture) begin
            r_mem[r_wr_ptr] <= bif.bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rd_cnt      <= '0;
            r_post_cnt    <= '0;
            r_wrapped     <= 1'b0;
            r_first       <= 1'b0;
            r_last_sample <= '0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_last     <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            if (bif.arm) begin
                r_state   <= S_ARMED;
                r_wr_ptr  <= '0;
                r_count   <= '0;
                r_rd_cnt  <= '0;
                r_wrapped <= 1'b0;
                r_first   <= 1'b1;
            end else begin
                if (w_capture) begin
                    r_wr_ptr      <= w_wr_ptr_nxt;
                    r_wrapped     <= w_wrapped_nxt;
                    r_first       <= 1'b0;
                    r_last_sample <= bif.bus;
                    if (r_count != FULL) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                case (r_state)
                    S_ARMED: begin
                        if (w_capture && w_match) begin
                            r_post_cnt <= POST_V;
                            if (POST == 0) begin
                                r_state  <= S_DONE;
                                r_rd_ptr <= w_rd_start;
                                r_rd_cnt <= '0;
                            end else begin
                                r_state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (w_capture) begin
                            r_post_cnt <= r_post_cnt - 1'b1;
                            if (r_post_cnt == AW'(1)) begin
                                r_state  <= S_DONE;
                                r_rd_ptr <= w_rd_start;
                                r_rd_cnt <= '0;
                            end
                        end
                    end
                    S_DONE: begin
                        if (bif.rd_req) begin
                            r_rd_data  <= r_mem[r_rd_ptr];
                            r_rd_valid <= 1'b1;
                            r_rd_last  <= w_rd_end;
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                            r_rd_cnt   <= r_rd_cnt + 1'b1;
                            if (w_rd_end) begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_led[3:0] = {r_wrapped, r_state == S_DONE, r_state == S_POST, r_state == S_ARMED};

    generate
        if (LED_N > 4) begin : g_led_cnt
            assign w_led[LED_N-1:4] = (LED_N-4)'(r_count);
        end
    endgenerate

    assign bif.rd_data  = r_rd_data;
    assign bif.rd_valid = r_rd_valid;
    assign bif.rd_last  = r_rd_last;
    assign bif.state    = r_state;
    assign bif.count    = r_count;
    assign bif.led      = w_led;
endmodule
